truth_table_sequencer: RTL
==========================

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, meaning cycles dut_x is held stable before dut_y is sampled; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request a full sweep; honoured only in IDLE.
REQ-005 The block SHALL have port expected, input, 16, golden truth table; bit i is the required dut_y for dut_x==i.
REQ-006 The block SHALL have port dut_x, output, 4, registered stimulus vector to the 4-input combinational circuit under control.
REQ-007 The block SHALL have port dut_y, input, 1, circuit output.
REQ-008 The block SHALL have port busy, output, 1, high in SETTLE and SAMPLE.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse in DONE.
REQ-010 The block SHALL have port table_out, output, 16, captured truth table; bit i is the dut_y sampled for vector i.
REQ-011 The block SHALL have port err_count, output, 5, count of vectors where the captured bit differs from the expected bit (0..16).
REQ-012 The block SHALL have port first_err, output, 4, lowest failing vector index.
REQ-013 The block SHALL have port first_err_valid, output, 1, high once any mismatch is recorded in the current sweep.
REQ-014 The block SHALL have port pass, output, 1, registered in DONE as (err_count==0); held until the next accepted start.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-016 IDLE, start=1: latch expected; clear table_out, err_count, first_err, first_err_valid and pass; load idx=0, dut_x=0, settle counter=SETTLE; go to SETTLE.
REQ-017 SETTLE SHALL decrement the counter each cycle and go to SAMPLE after exactly SETTLE cycles in SETTLE.
REQ-018 SAMPLE SHALL write table_out[idx]=dut_y; on mismatch with the latched expected[idx], err_count SHALL increment, and if first_err_valid==0, first_err=idx and first_err_valid=1.
REQ-019 SAMPLE with idx<15 SHALL set idx=idx+1, dut_x=idx+1, counter=SETTLE and go to SETTLE; with idx==15 SHALL go to DONE.
REQ-020 DONE SHALL assert done for exactly one cycle, register pass, set dut_x=0 and return to IDLE.
REQ-021 Latency: done SHALL be high in the cycle following the 16*(SETTLE+1)-th rising edge after the edge that accepted start (SETTLE=1 -> 32 edges).
REQ-022 start SHALL be ignored in SETTLE, SAMPLE and DONE; no queuing, and a start held high into IDLE SHALL be accepted on the first IDLE cycle.
REQ-023 Changes to expected after acceptance SHALL NOT affect the sweep in progress.
REQ-024 idx SHALL NOT wrap: vector 15 is the last sample, and err_count saturation is unnecessary since its 5-bit width holds 16.
REQ-025 table_out, err_count, first_err, first_err_valid and pass SHALL hold after DONE until the next accepted start.

Reset
REQ-026 rst_n low SHALL, immediately and regardless of clk, force state=IDLE, dut_x=0, idx=0, counter=0, busy=0, done=0, table_out=0, err_count=0, first_err=0, first_err_valid=0 and pass=0.
REQ-027 Reset asserted mid-sweep SHALL abort it with no done pulse; after release a new start SHALL begin from vector 0.

Verification
REQ-028 The bench SHALL cover: dut_y=x[3]&x[2], expected=16'hF000, SETTLE=1 -> table_out=16'hF000, err_count=0, pass=1, first_err_valid=0, done 32 edges after start.
REQ-029 The bench SHALL cover: same circuit, expected=16'hF001 -> err_count=1, first_err=0, first_err_valid=1, pass=0.
REQ-030 The bench SHALL cover: expected=16'h0FFF (all bits wrong) -> err_count=16, first_err=0, pass=0.
REQ-031 The bench SHALL cover: SETTLE=3 -> each dut_x value held 4 cycles, done 64 edges after start.
REQ-032 The bench SHALL cover: start pulsed while busy at vector 5 -> sweep unaffected, exactly one done.
REQ-033 The bench SHALL cover: rst_n low at vector 7 -> all outputs 0 at once, no done; a new start then gives a complete correct sweep.

Source files
------------

// File: rtl/truth_table_sequencer.sv
// Sweeps a 4-input combinational circuit through all 16 input vectors,
// captures its truth table and compares it against a golden table.
module truth_table_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] expected,
  output logic [3:0]  dut_x,
  input  logic        dut_y,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err,
  output logic        first_err_valid,
  output logic        pass
);

  localparam int unsigned XW    = 4;
  localparam int unsigned NVEC  = 16;
  localparam int unsigned CNTW  = 4;
  localparam int unsigned ERRW  = 5;
  localparam logic [XW-1:0] LAST_IDX = XW'(NVEC - 1);
  localparam logic [CNTW-1:0] SETTLE_LD = CNTW'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state, w_state;
  logic [XW-1:0]      r_idx, w_idx;
  logic [CNTW-1:0]    r_cnt, w_cnt;
  logic [XW-1:0]      r_dut_x, w_dut_x;
  logic [NVEC-1:0]    r_exp, w_exp;
  logic [NVEC-1:0]    r_table, w_table;
  logic [ERRW-1:0]    r_err_count, w_err_count;
  logic [XW-1:0]      r_first_err, w_first_err;
  logic               r_first_err_valid, w_first_err_valid;
  logic               r_pass, w_pass;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               w_mismatch;

  assign w_mismatch = dut_y ^ r_exp[r_idx];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= S_IDLE;
      r_idx             <= '0;
      r_cnt             <= '0;
      r_dut_x           <= '0;
      r_exp             <= '0;
      r_table           <= '0;
      r_err_count       <= '0;
      r_first_err       <= '0;
      r_first_err_valid <= 1'b0;
      r_pass            <= 1'b0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
    end else begin
      r_state           <= w_state;
      r_idx             <= w_idx;
      r_cnt             <= w_cnt;
      r_dut_x           <= w_dut_x;
      r_exp             <= w_exp;
      r_table           <= w_table;
      r_err_count       <= w_err_count;
      r_first_err       <= w_first_err;
      r_first_err_valid <= w_first_err_valid;
      r_pass            <= w_pass;
      r_busy            <= w_busy;
      r_done            <= w_done;
    end
  end

  // Next-state and next-output logic; busy/done are computed for the
  // state being entered so their registers line up with the state.
  always_comb begin
    w_state           = r_state;
    w_idx             = r_idx;
    w_cnt             = r_cnt;
    w_dut_x           = r_dut_x;
    w_exp             = r_exp;
    w_table           = r_table;
    w_err_count       = r_err_count;
    w_first_err       = r_first_err;
    w_first_err_valid = r_first_err_valid;
    w_pass            = r_pass;
    w_busy            = 1'b0;
    w_done            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_exp             = expected;
          w_table           = '0;
          w_err_count       = '0;
          w_first_err       = '0;
          w_first_err_valid = 1'b0;
          w_pass            = 1'b0;
          w_idx             = '0;
          w_dut_x           = '0;
          w_cnt             = SETTLE_LD;
          w_busy            = 1'b1;
          w_state           = S_SETTLE;
        end
      end

      S_SETTLE: begin
        w_busy = 1'b1;
        w_cnt  = r_cnt - CNTW'(1);
        if (r_cnt <= CNTW'(1)) begin
          w_state = S_SAMPLE;
        end
      end

      S_SAMPLE: begin
        w_table[r_idx] = dut_y;
        if (w_mismatch) begin
          w_err_count = r_err_count + ERRW'(1);
          if (!r_first_err_valid) begin
            w_first_err       = r_idx;
            w_first_err_valid = 1'b1;
          end
        end
        if (r_idx == LAST_IDX) begin
          w_done  = 1'b1;
          w_state = S_DONE;
        end else begin
          w_idx   = r_idx + XW'(1);
          w_dut_x = r_idx + XW'(1);
          w_cnt   = SETTLE_LD;
          w_busy  = 1'b1;
          w_state = S_SETTLE;
        end
      end

      S_DONE: begin
        w_pass  = (r_err_count == '0);
        w_dut_x = '0;
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign dut_x           = r_dut_x;
  assign busy            = r_busy;
  assign done            = r_done;
  assign table_out       = r_table;
  assign err_count       = r_err_count;
  assign first_err       = r_first_err;
  assign first_err_valid = r_first_err_valid;
  assign pass            = r_pass;

endmodule
